// File: rtl/l2_cache_control_if.sv
// rtl/l2_cache_control_if.sv - L1/pmem handshake and datapath control bundle for the L2 controller
//
// Purpose: groups every non-clock/reset signal of l2_cache_control.
// Modports:
//   master - controller view: drives handshakes, array write enables, selects and counters
//   slave  - datapath / requester / pmem view: drives requests, pmem_resp and set status
// Signals:
//   mem_read, mem_write, mem_resp        L1 request / completion pulse
//   pmem_read, pmem_write, pmem_resp     line fetch / writeback handshake
//   hit, way_hit, valid_out, dirty_out   status of the currently indexed set
//   plru                                 pseudo-LRU way of the current set
//   way_load, valid_load, valid_in,
//   dirty_load, dirty_in                 per-way tag/valid/dirty write controls
//   lru_load, mru                        PLRU update strobe and value
//   way_sel, pmem_address_sel,
//   way_data_in_sel, way_write_en        datapath muxes and data array write enables
//   hit_count, miss_count                saturating performance counters

interface l2_cache_control_if #(
    parameter int CNT_W = 32
);
    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;
    logic             hit;
    logic [7:0]       way_hit;
    logic [7:0]       valid_out;
    logic [7:0]       dirty_out;
    logic [2:0]       plru;
    logic [7:0]       way_load;
    logic [7:0]       valid_load;
    logic [7:0]       valid_in;
    logic [7:0]       dirty_load;
    logic [7:0]       dirty_in;
    logic             lru_load;
    logic [2:0]       mru;
    logic [2:0]       way_sel;
    logic [3:0]       pmem_address_sel;
    logic             way_data_in_sel;
    logic [7:0]       way_write_en;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        input  mem_read, mem_write, pmem_resp, hit, way_hit, valid_out, dirty_out, plru,
        output mem_resp, pmem_read, pmem_write, way_load, valid_load, valid_in,
               dirty_load, dirty_in, lru_load, mru, way_sel, pmem_address_sel,
               way_data_in_sel, way_write_en, hit_count, miss_count
    );

    modport slave (
        output mem_read, mem_write, pmem_resp, hit, way_hit, valid_out, dirty_out, plru,
        input  mem_resp, pmem_read, pmem_write, way_load, valid_load, valid_in,
               dirty_load, dirty_in, lru_load, mru, way_sel, pmem_address_sel,
               way_data_in_sel, way_write_en, hit_count, miss_count
    );
endinterface

// File: rtl/l2_cache_control.sv
// rtl/l2_cache_control.sv - control FSM for the 8-way, 8-set, 256-bit-line L2 cache
//
// Purpose: resolves hits, selects a victim way on a miss, writes back dirty
// victims, fetches missing lines and keeps saturating hit/miss counters.
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_ni  asynchronous active-low reset; every output is 0 while low
//   bus     l2_cache_control_if.master (L1 handshake, pmem handshake,
//           set status in, datapath controls and counters out)

module l2_cache_control #(
    parameter int NUM_WAYS = 8,
    parameter int CNT_W    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    l2_cache_control_if.master    bus
);

    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FETCH     = 3'd3,
        S_REFILLED  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    // Set while the CHECK that follows a refill is pending, so the
    // completing look-up is not counted a second time.
    logic               recheck_q, recheck_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;

    logic               req;
    logic               is_write;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_pick;
    logic [NUM_WAYS-1:0] hit_onehot;
    logic [NUM_WAYS-1:0] victim_onehot;
    logic               count_hit;
    logic               count_miss;

    // A simultaneous read and write is serviced as a write.
    assign req      = bus.mem_read | bus.mem_write;
    assign is_write = bus.mem_write;

    // Index of the hitting way; lowest set bit wins should the tag array
    // ever report more than one.
    always_comb begin
        logic found;
        hit_way = '0;
        found   = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && bus.way_hit[w]) begin
                hit_way = WAY_W'(w);
                found   = 1'b1;
            end
        end
    end

    // Victim: fill an empty way first (lowest index), otherwise evict the
    // pseudo-LRU way.
    always_comb begin
        logic found;
        victim_pick = bus.plru;
        found       = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found && !bus.valid_out[w]) begin
                victim_pick = WAY_W'(w);
                found       = 1'b1;
            end
        end
    end

    assign hit_onehot    = NUM_WAYS'(1) << hit_way;
    assign victim_onehot = NUM_WAYS'(1) << victim_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            victim_q  <= '0;
            recheck_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            victim_q  <= victim_d;
            recheck_q <= recheck_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        recheck_d = recheck_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d   = S_CHECK;
                    recheck_d = 1'b0;
                end
            end
            S_CHECK: begin
                // A request withdrawn after a refill has nothing left to answer.
                if (!req || bus.hit) begin
                    state_d   = S_IDLE;
                    recheck_d = 1'b0;
                end else begin
                    victim_d = victim_pick;
                    if (bus.valid_out[victim_pick] && bus.dirty_out[victim_pick]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                if (bus.pmem_resp) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.pmem_resp) begin
                    state_d = S_REFILLED;
                end
            end
            S_REFILLED: begin
                // One cycle for the freshly written tag/valid to be visible
                // before the look-up is repeated.
                state_d   = S_CHECK;
                recheck_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        bus.mem_resp         = 1'b0;
        bus.pmem_read        = 1'b0;
        bus.pmem_write       = 1'b0;
        bus.way_load         = '0;
        bus.valid_load       = '0;
        bus.valid_in         = '0;
        bus.dirty_load       = '0;
        bus.dirty_in         = '0;
        bus.lru_load         = 1'b0;
        bus.mru              = '0;
        bus.way_sel          = '0;
        bus.pmem_address_sel = '0;
        bus.way_data_in_sel  = 1'b0;
        bus.way_write_en     = '0;
        count_hit            = 1'b0;
        count_miss           = 1'b0;
        case (state_q)
            S_CHECK: begin
                if (req) begin
                    if (bus.hit) begin
                        bus.way_sel  = hit_way;
                        bus.lru_load = 1'b1;
                        bus.mru      = hit_way;
                        bus.mem_resp = 1'b1;
                        if (is_write) begin
                            bus.way_write_en    = hit_onehot;
                            bus.way_data_in_sel = 1'b1;
                            bus.dirty_load      = hit_onehot;
                            bus.dirty_in        = hit_onehot;
                        end
                        count_hit = !recheck_q;
                    end else begin
                        count_miss = !recheck_q;
                    end
                end
            end
            S_WRITEBACK: begin
                bus.pmem_write       = 1'b1;
                // Select 0 is the CPU address; writeback addresses start at 1.
                bus.pmem_address_sel = 4'({1'b0, victim_q}) + 4'd1;
                bus.way_sel          = victim_q;
            end
            S_FETCH: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    bus.way_write_en = victim_onehot;
                    bus.way_load     = victim_onehot;
                    bus.valid_load   = victim_onehot;
                    bus.valid_in     = victim_onehot;
                    bus.dirty_load   = victim_onehot;
                end
            end
            default: begin
            end
        endcase
    end

    // Saturating performance counters
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (count_hit && (hit_count_q != '1)) begin
            hit_count_d = hit_count_q + CNT_W'(1);
        end
        if (count_miss && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

endmodule
